// File: rtl/strb_tap_ctrl.sv
// rtl/strb_tap_ctrl.sv - tap controller for the 64-deep strobe delay line
// Optional calibration scan built only when STRB_TAP_SCAN_EN is defined.
module strb_tap_ctrl #(
    parameter int SETTLE = 64,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [5:0]       wr_tap,
    output logic             wr_ready,
    input  logic             scan_start,
    input  logic             strb_out,
    input  logic             ref_in,
    output logic [5:0]       tap,
    output logic             busy,
    output logic             scan_done,
    output logic [5:0]       best_tap,
    output logic [CNT_W-1:0] best_score
);

`ifdef STRB_TAP_SCAN_EN

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int TW    = (CNT_W > SET_W) ? CNT_W : SET_W;
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] WIN_LAST    = TW'((1 << CNT_W) - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] cnt;

    logic settle_end;
    logic win_end;
    logic last_tap;
    logic better;
    logic start_ok;

    assign settle_end = (timer == SETTLE_LAST);
    assign win_end    = (timer == WIN_LAST);
    assign last_tap   = (tap == 6'd63);
    assign better     = (cnt > best_score);
    // a simultaneous write wins over a scan request
    assign start_ok   = scan_start && !wr_valid;
    assign wr_ready   = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start_ok) state_next = S_SETTLE;
            S_SETTLE:  if (settle_end) state_next = S_MEASURE;
            S_MEASURE: if (win_end) state_next = S_COMPARE;
            S_COMPARE: state_next = last_tap ? S_DONE : S_SETTLE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap        <= 6'd0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            best_tap   <= 6'd0;
            best_score <= '0;
            timer      <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_valid) begin
                        tap <= wr_tap;
                    end else if (scan_start) begin
                        tap        <= 6'd0;
                        busy       <= 1'b1;
                        best_tap   <= 6'd0;
                        best_score <= '0;
                        timer      <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_end) begin
                        timer <= '0;
                        cnt   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_MEASURE: begin
                    // window length equals the counter maximum, so no saturation needed
                    cnt   <= cnt + CNT_W'(strb_out & ref_in);
                    timer <= win_end ? '0 : timer + 1'b1;
                end
                S_COMPARE: begin
                    if (better) begin
                        best_score <= cnt;
                        best_tap   <= tap;
                    end
                    if (last_tap) begin
                        // park on the winner so tap is valid in the scan_done cycle
                        tap       <= better ? tap : best_tap;
                        scan_done <= 1'b1;
                    end else begin
                        tap <= tap + 6'd1;
                    end
                end
                S_DONE: begin
                    scan_done <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    busy      <= 1'b0;
                    scan_done <= 1'b0;
                end
            endcase
        end
    end

`else

    logic unused_scan_inputs;
    assign unused_scan_inputs = &{1'b0, scan_start, strb_out, ref_in};

    assign wr_ready   = rst_n;
    assign busy       = 1'b0;
    assign scan_done  = 1'b0;
    assign best_tap   = 6'd0;
    assign best_score = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap <= 6'd0;
        end else if (wr_valid) begin
            tap <= wr_tap;
        end
    end

`endif

endmodule

// File: tb/tb_strb_tap_ctrl.sv
// tb/tb_strb_tap_ctrl.sv - directed bench for strb_tap_ctrl
module tb_strb_tap_ctrl;

    localparam int SETTLE = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_valid;
    logic [5:0]       wr_tap;
    logic             wr_ready;
    logic             scan_start;
    logic             strb_out;
    logic             ref_in;
    logic [5:0]       tap;
    logic             busy;
    logic             scan_done;
    logic [5:0]       best_tap;
    logic [CNT_W-1:0] best_score;

    int mode = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // delay-line stand-in: strobe coincides with reference only on chosen taps
    assign strb_out = (mode == 1 && tap == 6'd22) ||
                      (mode == 2 && (tap == 6'd10 || tap == 6'd40));

    strb_tap_ctrl #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_tap     (wr_tap),
        .wr_ready   (wr_ready),
        .scan_start (scan_start),
        .strb_out   (strb_out),
        .ref_in     (ref_in),
        .tap        (tap),
        .busy       (busy),
        .scan_done  (scan_done),
        .best_tap   (best_tap),
        .best_score (best_score)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_scan(output int n, output int busy_low);
        scan_start = 1'b1;
        tick(1);
        scan_start = 1'b0;
        n = 1;
        busy_low = (busy !== 1'b1) ? 1 : 0;
        while (scan_done !== 1'b1 && n < 2000) begin
            tick(1);
            n++;
            if (busy !== 1'b1) busy_low++;
        end
    endtask

    int n;
    int busy_low;

    initial begin
        rst_n      = 1'b0;
        wr_valid   = 1'b0;
        wr_tap     = 6'd0;
        scan_start = 1'b0;
        ref_in     = 1'b1;
        tick(2);

        check("rst_tap", tap, 0);
        check("rst_busy", busy, 0);
        check("rst_done", scan_done, 0);
        check("rst_best_tap", best_tap, 0);
        check("rst_best_score", best_score, 0);
`ifdef STRB_TAP_SCAN_EN
        check("rst_wr_ready", wr_ready, 1);
`else
        check("rst_wr_ready", wr_ready, 0);
`endif

        rst_n = 1'b1;
        tick(1);
        check("idle_wr_ready", wr_ready, 1);

        wr_valid = 1'b1;
        wr_tap   = 6'd37;
        tick(1);
        check("wr37_tap", tap, 37);
        check("wr37_ready", wr_ready, 1);
        wr_tap = 6'd5;
        tick(1);
        check("b2b_tap5", tap, 5);
        wr_tap = 6'd6;
        tick(1);
        check("b2b_tap6", tap, 6);
        wr_valid = 1'b0;
        tick(1);
        check("hold_tap6", tap, 6);

        wr_valid   = 1'b1;
        wr_tap     = 6'd9;
        scan_start = 1'b1;
        tick(1);
        wr_valid   = 1'b0;
        scan_start = 1'b0;
        check("contend_tap", tap, 9);
        check("contend_busy", busy, 0);
        tick(1);
        check("contend_no_scan", busy, 0);
        check("contend_ready", wr_ready, 1);

`ifdef STRB_TAP_SCAN_EN
        mode       = 1;
        scan_start = 1'b1;
        tick(1);
        scan_start = 1'b0;
        n = 1;
        check("scan_busy_start", busy, 1);
        check("scan_tap_start", tap, 0);
        check("scan_wr_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_tap   = 6'd50;
        busy_low = 0;
        tick(1);
        n++;
        check("scan_wr_ignored", tap, 0);
        wr_valid = 1'b0;
        while (scan_done !== 1'b1 && n < 2000) begin
            tick(1);
            n++;
            if (busy !== 1'b1) busy_low++;
        end
        check("scan22_len", n, 1281);
        check("scan22_busy_gaps", busy_low, 0);
        check("scan22_done_busy", busy, 1);
        check("scan22_best_tap", best_tap, 22);
        check("scan22_best_score", best_score, 15);
        check("scan22_tap", tap, 22);
        tick(1);
        check("scan22_done_pulse", scan_done, 0);
        check("scan22_busy_off", busy, 0);
        check("scan22_ready_back", wr_ready, 1);
        check("scan22_tap_hold", tap, 22);

        mode = 2;
        run_scan(n, busy_low);
        check("tie_len", n, 1281);
        check("tie_best_tap", best_tap, 10);
        check("tie_best_score", best_score, 15);
        check("tie_tap", tap, 10);
        tick(1);

        mode     = 0;
        wr_valid = 1'b1;
        wr_tap   = 6'd33;
        tick(1);
        wr_valid = 1'b0;
        check("pre_zero_tap", tap, 33);
        scan_start = 1'b1;
        tick(1);
        scan_start = 1'b0;
        check("zero_cleared_score", best_score, 0);
        check("zero_cleared_tap", best_tap, 0);
        n = 1;
        while (scan_done !== 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
        check("zero_len", n, 1281);
        check("zero_best_tap", best_tap, 0);
        check("zero_best_score", best_score, 0);
        check("zero_tap", tap, 0);
        tick(2);

        mode       = 2;
        scan_start = 1'b1;
        tick(1);
        scan_start = 1'b0;
        tick(299);
        check("mid_busy", busy, 1);
        check("mid_tap", tap, 14);
        check("mid_best_tap", best_tap, 10);
        check("mid_best_score", best_score, 15);
        rst_n = 1'b0;
        #1;
        check("abort_tap", tap, 0);
        check("abort_busy", busy, 0);
        check("abort_best_tap", best_tap, 0);
        check("abort_best_score", best_score, 0);
        check("abort_done", scan_done, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("abort_idle_ready", wr_ready, 1);
        busy_low = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (busy !== 1'b0 || scan_done !== 1'b0) busy_low++;
        end
        check("abort_stays_idle", busy_low, 0);
`else
        mode       = 1;
        scan_start = 1'b1;
        tick(1);
        scan_start = 1'b0;
        check("noscan_busy", busy, 0);
        check("noscan_tap", tap, 9);
        check("noscan_ready", wr_ready, 1);
        busy_low = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (busy !== 1'b0 || scan_done !== 1'b0 || tap !== 6'd9) busy_low++;
        end
        check("noscan_quiet", busy_low, 0);
        check("noscan_best_tap", best_tap, 0);
        check("noscan_best_score", best_score, 0);
        rst_n = 1'b0;
        #1;
        check("rst2_tap", tap, 0);
        check("rst2_ready", wr_ready, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("rst2_ready_back", wr_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/strb_tap_ctrl.md
# strb_tap_ctrl

Tap controller for the 64-deep strobe delay line. Owns the line's 6-bit `tap` select and accepts host tap writes over a valid/ready handshake. Optionally runs an automatic calibration scan: it sweeps all 64 taps, scores each tap by counting coincidences between the delayed strobe and a reference pulse, then parks on the best tap. It sits between the register interface and the strobe shifter, in the shifter's clock domain.

## Interface
- `SETTLE`, default 64: flush cycles after each tap change before measuring, at least the delay-line depth. Must be ≥ 1.
- `CNT_W`, default 8: width of the coincidence counter. The measurement window is WIN = 2^CNT_W − 1 cycles.
- `clk`  in  1  shifter clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  host tap-write request.
- `wr_tap`  in  6  requested tap.
- `wr_ready`  out  1  controller can accept a write.
- `scan_start`  in  1  single-cycle request to start a calibration scan.
- `strb_out`  in  1  delayed strobe returned from the delay line.
- `ref_in`  in  1  reference pulse, synchronous to `clk`.
- `tap`  out  6  registered tap select driven to the delay line.
- `busy`  out  1  high while a scan is in progress.
- `scan_done`  out  1  one-cycle pulse when a scan completes.
- `best_tap`  out  6  winning tap of the last completed scan.
- `best_score`  out  CNT_W  score of `best_tap`.

## Operation
- States: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- Reset (asynchronous, while `rst_n` = 0) forces:
  - state = IDLE
  - `tap` = 0, `busy` = 0, `scan_done` = 0
  - `best_tap` = 0, `best_score` = 0
  - all counters = 0
- Assertion of `rst_n` mid-scan aborts the scan with no partial results kept.
- `wr_ready` = 1 only in IDLE.
- A write completes on `wr_valid` & `wr_ready`. `tap` takes `wr_tap` on the next edge.
- IDLE accepts writes back-to-back, one per cycle.
- If `scan_start` and `wr_valid` are both high in IDLE, the write is accepted and `scan_start` is dropped.
- `scan_start` outside IDLE is ignored. Scan requests are not queued.
- IDLE → SETTLE on `scan_start`:
  - `tap` = 0, `busy` = 1
  - `best_score` = 0, `best_tap` = 0
  - settle counter = 0
- SETTLE: runs for SETTLE cycles, then → MEASURE with the coincidence counter cleared.
- MEASURE: runs for WIN cycles. The counter increments on each cycle where `strb_out` & `ref_in`. It cannot overflow, since its maximum is WIN. Then → COMPARE.
- COMPARE (1 cycle):
  - If count > `best_score` (strict), then `best_score` = count and `best_tap` = `tap`. Ties therefore keep the lowest tap.
  - If `tap` = 63, go to DONE. Otherwise increment `tap` and go to SETTLE.
  - `tap` never wraps during a scan.
- DONE (1 cycle): `tap` = `best_tap`, `scan_done` = 1, `busy` = 0 from the next cycle, then → IDLE.
- If every score is 0, the result is `best_tap` = 0 and `best_score` = 0, and the controller parks on tap 0.
- `best_tap` and `best_score` hold until the next scan starts or reset.

## Timing
- Write accepted at edge T: `tap` is valid after T+1.
- Scan start sampled at edge T: `busy` = 1 and `tap` = 0 from T+1.
- Per tap: SETTLE + WIN + 1 cycles.
- Whole scan: 64·(SETTLE + WIN + 1) + 1 cycles from T+1 to the `scan_done` cycle. `tap` = `best_tap` in that same cycle.
- `scan_done` is high for exactly one cycle. It coincides with the last `busy` = 1 cycle.
- `wr_ready` rises in the cycle after `scan_done`.
- All outputs are registered, with no combinational input-to-output paths, except `wr_ready`, which is decoded from state.

## Configuration
- Macro `STRB_TAP_SCAN_EN`.
- Defined: full behaviour as above.
- Undefined:
  - The scan FSM and counters are not built. Only the IDLE write path remains.
  - `scan_start`, `strb_out` and `ref_in` are ignored.
  - `busy`, `scan_done`, `best_tap` and `best_score` are tied to 0.
  - `wr_ready` = 1 whenever out of reset.

## Test plan
All scenarios use SETTLE = 4, CNT_W = 4 (WIN = 15, 20 cycles per tap, scan 1281 cycles).
- Reset/write: release reset, then write 6'd37 → `tap` = 37 one cycle after the handshake. `wr_ready` stays 1, and back-to-back writes 5, 6 give `tap` = 5 then 6 on consecutive cycles.
- Full scan with `ref_in` = 1 and `strb_out` = 1 only while `tap` = 22 → `busy` high for 1281 cycles, then `scan_done` pulse, `best_tap` = 22, `best_score` = 15, `tap` = 22.
- Tie: `strb_out` = 1 for taps 10 and 40, both scoring 15 → `best_tap` = 10.
- No coincidences: `strb_out` = 0 throughout → `best_tap` = 0, `best_score` = 0, `tap` = 0 after `scan_done`.
- Contention:
  - `scan_start` and `wr_valid` (tap 9) in the same IDLE cycle → `tap` = 9, no scan.
  - `wr_valid` during a scan → `wr_ready` = 0, and `tap` is unaffected.
- Reset mid-scan: pull `rst_n` low at cycle 300 of a scan → outputs at reset values immediately, IDLE after release. With `STRB_TAP_SCAN_EN` undefined, `scan_start` has no effect.
